div_arbiter: RTL and testbench

// Time-multiplexes one pipelined div (remainder) instance among NUM_REQ requesters
// (star x/y, cloud level/gap, obstacle gap draws) so that horizon needs one divider, not one per use.

---
 rtl/div_arbiter.sv | 170 +++++++++++++++++
 tb/tb_div_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
//
// Shares one pipelined remainder divider among NUM_REQ requesters. A
// round-robin FSM grants one requester at a time, latches its operands onto
// the divider, waits out the divider latency, captures the remainder and
// pulses that requester's done bit. A zero denominator is answered directly
// (remain=0, div_err=1) without ever driving zero into the divider.
//
// Ports
//   clk         system clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   req         per-requester request, held until its done
//   numer       per-requester numerator, stable while req is high
//   denom       per-requester denominator, stable while req is high
//   done        one-hot single-cycle pulse: remain is valid for that requester
//   remain      shared result register, holds until the next done
//   div_err     pulses with done when the served denominator was zero
//   busy        high whenever the FSM is not idle
//   div_numer   registered numerator driven to the shared divider
//   div_denom   registered denominator driven to the shared divider
//   div_remain  remainder returned by the shared divider
// ---------------------------------------------------------------------------
module div_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUMER_W     = 11,
    parameter int DENOM_W     = 11,
    parameter int DIV_LATENCY = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0][NUMER_W-1:0]   numer,
    input  logic [NUM_REQ-1:0][DENOM_W-1:0]   denom,
    output logic [NUM_REQ-1:0]                done,
    output logic [DENOM_W-1:0]                remain,
    output logic                              div_err,
    output logic                              busy,
    output logic [NUMER_W-1:0]                div_numer,
    output logic [DENOM_W-1:0]                div_denom,
    input  logic [DENOM_W-1:0]                div_remain
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] win_nxt_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic             any_req;
    logic             win_zero;

    // Round-robin winner: scan from the highest offset down so the last hit
    // written is the first set request at or after rr_ptr.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_idx  = '0;
        scan_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[scan_idx]) begin
                win_idx = scan_idx;
            end
        end
    end

    assign any_req     = |req;
    assign win_zero    = (denom[win_idx] == '0);
    assign win_nxt_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The wait counter is loaded with DIV_LATENCY and the
    // remainder is taken when it reaches zero, giving DIV_LATENCY+1 WAIT
    // cycles: the first one is spent presenting the operands.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = win_zero ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        done = '0;
        if (state == S_DONE) begin
            done[grant] = 1'b1;
        end
        busy = (state != S_IDLE);
    end

    // Datapath: grant bookkeeping, divider operands, counter, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant     <= '0;
            wait_cnt  <= '0;
            remain    <= '0;
            div_err   <= 1'b0;
            div_numer <= '0;
            div_denom <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant     <= win_idx;
                        rr_ptr    <= win_nxt_ptr;
                        div_numer <= numer[win_idx];
                        if (win_zero) begin
                            // Answered locally; div_denom keeps its previous
                            // value so the divider never sees a zero.
                            remain  <= '0;
                            div_err <= 1'b1;
                        end else begin
                            div_denom <= denom[win_idx];
                            wait_cnt  <= CNT_W'(DIV_LATENCY);
                            div_err   <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        remain <= div_remain;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    div_err <= 1'b0;
                end
                default: begin
                    div_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
//
// Drives div_arbiter with directed and randomized requester traffic and a
// behavioural pipelined divider. A transaction-level model predicts, per
// cycle, which requester completes when and with what result: an idle
// arbiter grants the first request at or after its pointer, a zero
// denominator completes one cycle later, any other two plus DIV_LATENCY
// cycles later, and the arbiter is idle again the cycle after completion.
// ---------------------------------------------------------------------------
module tb_div_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int NUMER_W     = 11;
    localparam int DENOM_W     = 11;
    localparam int DIV_LATENCY = 3;
    localparam int DEN_MAX     = (1 << DENOM_W) - 1;

    logic                            clk;
    logic                            rst_n;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0][NUMER_W-1:0] numer;
    logic [NUM_REQ-1:0][DENOM_W-1:0] denom;
    logic [NUM_REQ-1:0]              done;
    logic [DENOM_W-1:0]              remain;
    logic                            div_err;
    logic                            busy;
    logic [NUMER_W-1:0]              div_numer;
    logic [DENOM_W-1:0]              div_denom;
    logic [DENOM_W-1:0]              div_remain;

    div_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .NUMER_W    (NUMER_W),
        .DENOM_W    (DENOM_W),
        .DIV_LATENCY(DIV_LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .numer     (numer),
        .denom     (denom),
        .done      (done),
        .remain    (remain),
        .div_err   (div_err),
        .busy      (busy),
        .div_numer (div_numer),
        .div_denom (div_denom),
        .div_remain(div_remain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipelined divider: result appears DIV_LATENCY edges after the operands.
    logic [DENOM_W-1:0] pipe [DIV_LATENCY];
    always @(posedge clk) begin
        pipe[0] <= (div_denom == '0) ? '0 : DENOM_W'(div_numer % div_denom);
        for (int k = 1; k < DIV_LATENCY; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end
    assign div_remain = pipe[DIV_LATENCY-1];

    // Model state
    int                 t;
    int                 busy_until;
    int                 done_at;
    int                 m_ptr;
    int                 m_grant;
    logic [DENOM_W-1:0] m_res;
    logic [DENOM_W-1:0] m_remain;
    logic [DENOM_W-1:0] m_dden;
    logic [NUMER_W-1:0] m_dnum;
    bit                 m_err;
    bit                 drop_next [NUM_REQ];
    bit                 persist   [NUM_REQ];
    bit                 rand_en;
    int                 checks;
    int                 errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, t, obs, exp);
        end
    endtask

    task automatic raise(input int i, input logic [NUMER_W-1:0] n, input logic [DENOM_W-1:0] d);
        req[i]   = 1'b1;
        numer[i] = n;
        denom[i] = d;
    endtask

    task automatic model_reset();
        t          = 0;
        busy_until = -1;
        done_at    = -100;
        m_ptr      = 0;
        m_grant    = 0;
        m_res      = '0;
        m_remain   = '0;
        m_dden     = '0;
        m_dnum     = '0;
        m_err      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) drop_next[i] = 1'b0;
    endtask

    // Move to the next cycle: new requests first, then drop requesters whose
    // done appeared in the previous cycle.
    task automatic advance();
        @(posedge clk);
        #1;
        t++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] && !drop_next[i]) begin
                if (persist[i]) begin
                    raise(i, NUMER_W'($urandom), DENOM_W'($urandom_range(1, DEN_MAX)));
                end else if (rand_en && $urandom_range(0, 3) == 0) begin
                    raise(i, NUMER_W'($urandom),
                          ($urandom_range(0, 7) == 0) ? DENOM_W'(0)
                                                      : DENOM_W'($urandom_range(1, 64)));
                end
            end
            if (drop_next[i]) begin
                req[i]       = 1'b0;
                drop_next[i] = 1'b0;
            end
        end
    endtask

    // Compare this cycle's outputs with the model, then let the model sample
    // the request vector if the arbiter is idle.
    task automatic eval_cycle();
        logic [NUM_REQ-1:0] exp_done;
        bit                 exp_err;
        int                 w;
        int                 idx;
        exp_done = '0;
        exp_err  = 1'b0;
        if (t == done_at) begin
            exp_done[m_grant] = 1'b1;
            exp_err           = m_err;
            m_remain          = m_res;
            drop_next[m_grant] = 1'b1;
        end
        check("done",      32'(done),      32'(exp_done));
        check("busy",      32'(busy),      32'(t <= busy_until));
        check("remain",    32'(remain),    32'(m_remain));
        check("div_err",   32'(div_err),   32'(exp_err));
        check("div_numer", 32'(div_numer), 32'(m_dnum));
        check("div_denom", 32'(div_denom), 32'(m_dden));
        if (t > busy_until && req != '0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (w < 0 && req[idx]) w = idx;
            end
            m_grant = w;
            m_ptr   = (w + 1) % NUM_REQ;
            m_dnum  = numer[w];
            if (denom[w] == '0) begin
                m_err   = 1'b1;
                m_res   = '0;
                done_at = t + 1;
            end else begin
                m_err   = 1'b0;
                m_res   = DENOM_W'(int'(numer[w]) % int'(denom[w]));
                m_dden  = denom[w];
                done_at = t + 2 + DIV_LATENCY;
            end
            busy_until = done_at;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            advance();
            eval_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rand_en = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) persist[i] = 1'b0;
        model_reset();
        rst_n = 1'b0;
        req   = '0;
        numer = '0;
        denom = '0;

        // Reset state, then release with nothing requested.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        model_reset();
        eval_cycle();
        run(3);

        // Two simultaneous requests with the pointer at 0: 1 then 2.
        advance();
        raise(1, 11'd500, 11'd7);
        raise(2, 11'd300, 11'd11);
        eval_cycle();
        run(16);

        // Pointer now 3: zero-denominator request 3 beats request 0, then
        // request 0 (1000 % 37 = 1) five cycles after it is sampled.
        advance();
        raise(3, 11'd99, 11'd0);
        raise(0, 11'd1000, 11'd37);
        eval_cycle();
        run(14);

        // Bring the pointer back to 0, then all four requesters hold.
        advance();
        raise(3, 11'd77, 11'd5);
        eval_cycle();
        run(8);
        for (int i = 0; i < NUM_REQ; i++) persist[i] = 1'b1;
        run(40);
        for (int i = 0; i < NUM_REQ; i++) persist[i] = 1'b0;
        run(30);

        // Random traffic, then drain.
        rand_en = 1'b1;
        run(600);
        rand_en = 1'b0;
        run(40);

        // Request 2 withdrawn during WAIT still completes exactly once.
        advance();
        raise(2, 11'd1234, 11'd100);
        eval_cycle();
        run(2);
        advance();
        req[2] = 1'b0;
        eval_cycle();
        run(15);

        // Reset during WAIT aborts the operation; held requests are served
        // again starting from pointer 0.
        advance();
        raise(0, 11'd50, 11'd9);
        eval_cycle();
        run(12);
        advance();
        raise(0, 11'd641, 11'd13);
        raise(1, 11'd222, 11'd17);
        raise(3, 11'd1500, 11'd29);
        eval_cycle();
        run(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_done",      32'(done),      32'(0));
        check("arst_busy",      32'(busy),      32'(0));
        check("arst_remain",    32'(remain),    32'(0));
        check("arst_div_err",   32'(div_err),   32'(0));
        check("arst_div_numer", 32'(div_numer), 32'(0));
        check("arst_div_denom", 32'(div_denom), 32'(0));
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        eval_cycle();
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
